frame_sequencer: RTL
====================

// Module: frame_sequencer
// PURPOSE
//  Per-frame scheduler in the pixel_clk domain. Each vsync start it sequences three steps:
//  front/back framebuffer swap, back-buffer clear, then draining the sprite draw queue into
//  the sprite driver one entry at a time. Detects frame overruns and keeps frame statistics.
//  Sits between global_vsync, framebuffer_master and sprite_driver.
// PARAMETERS
//  VSYNC_ACTIVE_LOW  1        1: vsync active level is 0 (VGA timing); 0: active level is 1
//  CLEAR_TIMEOUT     2**20    max cycles spent in CLEAR_WAIT_HI + CLEAR_WAIT_LO before giving up
//  STAT_W            16       width of frame_count and overrun_count
// PORTS
//  clock          in   1       pixel clock; single clock domain
//  reset          in   1       synchronous, active-high
//  enable         in   1       1: vsync starts launch frames; 0: idle after the current frame
//  vsync          in   1       global vsync, same clock domain, no synchroniser
//  fb_resetting   in   1       framebuffer master clearing back buffer
//  queue_is_empty in   1       sprite draw queue empty
//  draw_busy      in   1       sprite driver drawing current sprite
//  stat_clear     in   1       pulse; clears sticky flags and counters
//  swap_req       out  1       1-cycle pulse: swap front/back buffers
//  clear_start    out  1       1-cycle pulse: start back-buffer clear
//  draw_start     out  1       1-cycle pulse: sprite driver dequeues and draws one sprite
//  frame_active   out  1       high in every state except IDLE
//  frame_done     out  1       1-cycle pulse: frame complete
//  overrun        out  1       sticky: vsync start arrived while a frame was in progress
//  clear_timeout  out  1       sticky: clear handshake exceeded CLEAR_TIMEOUT
//  frame_count    out  STAT_W  frames launched; wraps
//  overrun_count  out  STAT_W  overruns; saturates at all-ones
// BEHAVIOUR
//  - Reset: state=IDLE, pending=0, all outputs 0. vsync_prev resets to the ACTIVE level, so a
//    vsync held active through reset release does not start a frame. Reset mid-frame aborts
//    immediately; no pulses follow.
//  - vs_start (combinational) = vsync at active level && vsync_prev at inactive level;
//    vsync_prev <= vsync every cycle.
//  - Outputs are Moore decodes of the registered state:
//    swap_req = SWAP, clear_start = CLEAR_REQ, draw_start = DRAW_START, frame_done = DONE.
//  - Latency: vs_start seen in cycle N -> swap_req at N+1 -> clear_start at N+2.
//  - States and transitions:
//    IDLE:          vs_start && enable -> SWAP. vs_start with enable=0 is ignored (no overrun).
//    SWAP:          frame_count++ -> CLEAR_REQ
//    CLEAR_REQ:     tmo_cnt <= 0 -> CLEAR_WAIT_HI
//    CLEAR_WAIT_HI: fb_resetting=1 -> CLEAR_WAIT_LO
//    CLEAR_WAIT_LO: fb_resetting=0 -> DRAW_CHECK
//                   In both wait states: tmo_cnt++; at CLEAR_TIMEOUT-1 set clear_timeout
//                   and go to DRAW_CHECK.
//    DRAW_CHECK:    pending || queue_is_empty -> DONE; else -> DRAW_START
//    DRAW_START:    -> DRAW_ACK
//    DRAW_ACK:      draw_busy ignored this cycle -> DRAW_WAIT
//    DRAW_WAIT:     draw_busy=0 -> DRAW_CHECK
//    DONE:          pending && enable -> SWAP, clear pending; else clear pending -> IDLE
//  - Overrun: vs_start in any state other than IDLE or DONE:
//    set overrun, overrun_count++ (saturating), set pending.
//    A sprite already in flight always finishes; no further draw_start is issued that frame.
//    vs_start in DONE is treated as pending and gives SWAP next cycle; it is not an overrun.
//  - enable=0 mid-frame: the current frame completes normally.
//  - stat_clear: zeroes overrun, clear_timeout, frame_count, overrun_count.
//    Clear wins over a same-cycle increment or set.
//  - Width rules: tmo_cnt is $clog2(CLEAR_TIMEOUT)+1 bits; counters are unsigned.
// STRUCTURE
//  - frame_seq_pkg: typedef enum logic [3:0] fseq_state_t (the 10 states above).
//  - One sub-module, stat_counter #(W, SATURATE): inc/clr counter.
//    Used twice: wrap for frame_count, saturate for overrun_count.
//  - FSM, edge detector and timeout counter stay in frame_sequencer.
// TESTING
//  1. Reset released with vsync=0 (active low); vsync 1->0 at cycle 10, queue empty, fb_resetting
//     high for cycles 13-15:
//     -> swap_req@11, clear_start@12, frame_done@18, frame_count=1.
//  2. 3 queued sprites, draw_busy high 5 cycles after each draw_start:
//     -> exactly 3 draw_start pulses, each >=7 cycles apart; frame_done after the 3rd busy falls.
//  3. vsync start during the 2nd sprite's DRAW_WAIT:
//     -> overrun=1, overrun_count=1, no 3rd draw_start, frame_done then swap_req on the next cycle.
//  4. fb_resetting never rises, CLEAR_TIMEOUT=16:
//     -> clear_timeout=1 16 cycles after clear_start, then DRAW_CHECK proceeds.
//  5. overrun_count preloaded to 0xFFFF, one more overrun -> stays 0xFFFF.
//     stat_clear same cycle as overrun -> all counters and flags 0.
//  6. Reset in DRAW_WAIT -> next cycle all outputs 0, state IDLE, no pulses until a new
//     inactive->active vsync edge.

Source files
------------

// File: rtl/frame_seq_pkg.sv
// Shared types for the per-frame sequencer.
package frame_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SWAP,
    S_CLEAR_REQ,
    S_CLEAR_WAIT_HI,
    S_CLEAR_WAIT_LO,
    S_DRAW_CHECK,
    S_DRAW_START,
    S_DRAW_ACK,
    S_DRAW_WAIT,
    S_DONE
  } fseq_state_t;

endpackage

// File: rtl/frame_sequencer_stat_counter.sv
// Statistics counter with clear and increment; wraps or saturates.
module stat_counter #(
  parameter int W        = 16,
  parameter bit SATURATE = 1'b0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  // clear wins over a same-cycle increment; saturating mode holds at all-ones
  always_ff @(posedge clock) begin
    if (reset || clr)
      count <= '0;
    else if (inc && !(SATURATE && (&count)))
      count <= count + W'(1);
  end

endmodule

// File: rtl/frame_sequencer.sv
// Per-frame scheduler: buffer swap, back-buffer clear, then sprite queue drain.
module frame_sequencer
  import frame_seq_pkg::*;
#(
  parameter bit VSYNC_ACTIVE_LOW = 1'b1,
  parameter int CLEAR_TIMEOUT    = 2**20,
  parameter int STAT_W           = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              vsync,
  input  logic              fb_resetting,
  input  logic              queue_is_empty,
  input  logic              draw_busy,
  input  logic              stat_clear,
  output logic              swap_req,
  output logic              clear_start,
  output logic              draw_start,
  output logic              frame_active,
  output logic              frame_done,
  output logic              overrun,
  output logic              clear_timeout,
  output logic [STAT_W-1:0] frame_count,
  output logic [STAT_W-1:0] overrun_count
);

  localparam int               TMO_W    = $clog2(CLEAR_TIMEOUT) + 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(CLEAR_TIMEOUT - 1);
  localparam logic             VS_ACT   = VSYNC_ACTIVE_LOW ? 1'b0 : 1'b1;

  fseq_state_t      state;
  logic             vsync_prev;
  logic             pending;
  logic [TMO_W-1:0] tmo_cnt;

  logic vs_start;
  logic ovr_evt;
  logic in_wait;
  logic tmo_hit;

  assign vs_start = (vsync == VS_ACT) && (vsync_prev != VS_ACT);
  // a new frame start while mid-frame; DONE absorbs it as a back-to-back launch
  assign ovr_evt  = vs_start && (state != S_IDLE) && (state != S_DONE);
  assign in_wait  = (state == S_CLEAR_WAIT_HI) || (state == S_CLEAR_WAIT_LO);
  // a clean fb_resetting fall on the last allowed cycle is not a timeout
  assign tmo_hit  = in_wait && (tmo_cnt == TMO_LAST) &&
                    !((state == S_CLEAR_WAIT_LO) && !fb_resetting);

  assign swap_req     = (state == S_SWAP);
  assign clear_start  = (state == S_CLEAR_REQ);
  assign draw_start   = (state == S_DRAW_START);
  assign frame_done   = (state == S_DONE);
  assign frame_active = (state != S_IDLE);

  // vsync edge history; resets to active so a held-active vsync cannot launch a frame
  always_ff @(posedge clock) begin
    if (reset) vsync_prev <= VS_ACT;
    else       vsync_prev <= vsync;
  end

  // frame sequencing FSM with pending-frame tracking and clear timeout
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      pending <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      if (state == S_DONE) pending <= 1'b0;
      else if (ovr_evt)    pending <= 1'b1;

      case (state)
        S_IDLE:          if (vs_start && enable) state <= S_SWAP;
        S_SWAP:          state <= S_CLEAR_REQ;
        S_CLEAR_REQ: begin
          tmo_cnt <= '0;
          state   <= S_CLEAR_WAIT_HI;
        end
        S_CLEAR_WAIT_HI: begin
          tmo_cnt <= tmo_cnt + TMO_W'(1);
          if (tmo_hit)           state <= S_DRAW_CHECK;
          else if (fb_resetting) state <= S_CLEAR_WAIT_LO;
        end
        S_CLEAR_WAIT_LO: begin
          tmo_cnt <= tmo_cnt + TMO_W'(1);
          if (tmo_hit || !fb_resetting) state <= S_DRAW_CHECK;
        end
        // an overrun stops further dequeues; the in-flight sprite already finished
        S_DRAW_CHECK:    state <= (pending || queue_is_empty) ? S_DONE : S_DRAW_START;
        S_DRAW_START:    state <= S_DRAW_ACK;
        // driver may not have raised busy yet, so skip one cycle before watching it
        S_DRAW_ACK:      state <= S_DRAW_WAIT;
        S_DRAW_WAIT:     if (!draw_busy) state <= S_DRAW_CHECK;
        S_DONE:          state <= ((pending || vs_start) && enable) ? S_SWAP : S_IDLE;
        default:         state <= S_IDLE;
      endcase
    end
  end

  // sticky status flags; stat_clear wins over a same-cycle set
  always_ff @(posedge clock) begin
    if (reset || stat_clear) begin
      overrun       <= 1'b0;
      clear_timeout <= 1'b0;
    end else begin
      if (ovr_evt) overrun       <= 1'b1;
      if (tmo_hit) clear_timeout <= 1'b1;
    end
  end

  stat_counter #(.W(STAT_W), .SATURATE(1'b0)) u_frame_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (stat_clear),
    .inc   (state == S_SWAP),
    .count (frame_count)
  );

  stat_counter #(.W(STAT_W), .SATURATE(1'b1)) u_ovr_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (stat_clear),
    .inc   (ovr_evt),
    .count (overrun_count)
  );

endmodule
